// File: rtl/uart_ro_pkg.sv
// Shared types and constants for the two-channel UART readout scheduler.
package uart_ro_pkg;

   localparam int unsigned DATA_W = 14;
   localparam int unsigned CNT_W  = 6;
   localparam int unsigned FCNT_W = 16;

   localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;
   localparam logic [1:0] TRAIL_PFX    = 2'b11;
   localparam logic [1:0] HI_PFX       = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_CHID,
      ST_RDREQ,
      ST_WAITQ,
      ST_HI,
      ST_LO,
      ST_TRAIL
   } state_t;

   // Trailer carries the sample count under a prefix no hi byte can have.
   function automatic logic [7:0] trailer_byte(input logic [CNT_W-1:0] n);
      return {TRAIL_PFX, n};
   endfunction

endpackage

// File: rtl/uart_ro_arbiter_rr_pick2.sv
// Two-way round-robin chooser: on contention the channel not served last wins.
module rr_pick2 (
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic       o_grant_c,
   output logic       o_valid_c
);

   assign o_valid_c = |i_req;
   assign o_grant_c = (&i_req) ? ~i_last : i_req[1];

endmodule

// File: rtl/uart_ro_arbiter.sv
// Drains two ADC FIFOs in bounded bursts and frames each word as two bytes
// for the shared UART transmitter, alternating channels round-robin.
module uart_ro_arbiter
   import uart_ro_pkg::*;
#(
   parameter int unsigned BURST_LEN = 16,
   parameter logic [7:0]  HDR_BYTE  = HDR_BYTE_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] fifo0_q,
   input  logic              fifo0_empty,
   output logic              fifo0_rdreq,
   input  logic [DATA_W-1:0] fifo1_q,
   input  logic              fifo1_empty,
   output logic              fifo1_rdreq,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_done,
   output logic              busy,
   output logic              cur_ch,
   output logic [FCNT_W-1:0] frame_cnt
);

   state_t              r_state;
   logic [7:0]          r_tx_data;
   logic                r_tx_valid;
   logic                r_busy;
   logic                r_cur_ch;
   logic [FCNT_W-1:0]   r_frame_cnt;
   logic [1:0]          r_rdreq;
   logic [CNT_W-1:0]    r_n;
   logic [7:0]          r_lo_byte;

   logic [1:0]          w_req;
   logic                w_grant;
   logic                w_valid;
   logic [DATA_W-1:0]   w_q;
   logic                w_cur_empty;
   logic                w_burst_full;

   assign w_req        = {~fifo1_empty, ~fifo0_empty};
   assign w_q          = r_cur_ch ? fifo1_q : fifo0_q;
   assign w_cur_empty  = r_cur_ch ? fifo1_empty : fifo0_empty;
   assign w_burst_full = (r_n == CNT_W'(BURST_LEN));

   rr_pick2 u_pick (
      .i_req     (w_req),
      .i_last    (r_cur_ch),
      .o_grant_c (w_grant),
      .o_valid_c (w_valid)
   );

   // Frame sequencer; every output is loaded one cycle ahead of its state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_tx_data   <= '0;
         r_tx_valid  <= 1'b0;
         r_busy      <= 1'b0;
         r_cur_ch    <= 1'b1;
         r_frame_cnt <= '0;
         r_rdreq     <= 2'b00;
         r_n         <= '0;
         r_lo_byte   <= '0;
      end else begin
         r_rdreq <= 2'b00;
         unique case (r_state)
            ST_IDLE: begin
               if (w_valid) begin
                  r_cur_ch   <= w_grant;
                  r_n        <= '0;
                  r_busy     <= 1'b1;
                  r_tx_data  <= HDR_BYTE;
                  r_tx_valid <= 1'b1;
                  r_state    <= ST_HDR;
               end
            end
            ST_HDR: begin
               if (tx_done) begin
                  r_tx_data <= {7'b0, r_cur_ch};
                  r_state   <= ST_CHID;
               end
            end
            ST_CHID: begin
               if (tx_done) begin
                  r_tx_valid        <= 1'b0;
                  r_rdreq[r_cur_ch] <= 1'b1;
                  r_state           <= ST_RDREQ;
               end
            end
            ST_RDREQ: begin
               r_state <= ST_WAITQ;
            end
            ST_WAITQ: begin
               r_lo_byte  <= w_q[7:0];
               r_n        <= r_n + CNT_W'(1);
               r_tx_data  <= {HI_PFX, w_q[DATA_W-1:8]};
               r_tx_valid <= 1'b1;
               r_state    <= ST_HI;
            end
            ST_HI: begin
               if (tx_done) begin
                  r_tx_data <= r_lo_byte;
                  r_state   <= ST_LO;
               end
            end
            ST_LO: begin
               if (tx_done) begin
                  // Empty is sampled here, after the previous read has landed.
                  if (w_burst_full || w_cur_empty) begin
                     r_tx_data <= trailer_byte(r_n);
                     r_state   <= ST_TRAIL;
                  end else begin
                     r_tx_valid        <= 1'b0;
                     r_rdreq[r_cur_ch] <= 1'b1;
                     r_state           <= ST_RDREQ;
                  end
               end
            end
            ST_TRAIL: begin
               if (tx_done) begin
                  r_tx_valid  <= 1'b0;
                  r_busy      <= 1'b0;
                  r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign fifo0_rdreq = r_rdreq[0];
   assign fifo1_rdreq = r_rdreq[1];
   assign tx_data     = r_tx_data;
   assign tx_valid    = r_tx_valid;
   assign busy        = r_busy;
   assign cur_ch      = r_cur_ch;
   assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_uart_ro_arbiter.sv
// Bench for uart_ro_arbiter: FIFO and transmitter models plus a frame-level
// reference that rebuilds the byte stream from queue contents.
module tb_uart_ro_arbiter;

   localparam int BURST = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [13:0] fifo0_q = '0, fifo1_q = '0;
   logic        fifo0_empty = 1'b1, fifo1_empty = 1'b1;
   logic        fifo0_rdreq, fifo1_rdreq;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_done = 1'b0;
   logic        busy, cur_ch;
   logic [15:0] frame_cnt;

   logic [13:0] q0[$], q1[$], m0[$], m1[$];
   logic [7:0]  got[$], exp_bytes[$];
   int compared = 0, mismatched = 0;
   int rd0_cnt = 0, rd1_cnt = 0, rd_both = 0, underflow = 0, stab_err = 0;
   int tx_mode = 1, tx_delay = 4, hold_idx = -1, hold_delay = 0, tx_cnt = 0;
   logic        prev_valid = 1'b0;
   logic [7:0]  prev_data = '0;
   logic        m_last = 1'b1;
   logic [15:0] exp_frames = '0;

   uart_ro_arbiter #(.BURST_LEN(BURST), .HDR_BYTE(8'hA5)) dut (
      .clk(clk), .rst_n(rst_n),
      .fifo0_q(fifo0_q), .fifo0_empty(fifo0_empty), .fifo0_rdreq(fifo0_rdreq),
      .fifo1_q(fifo1_q), .fifo1_empty(fifo1_empty), .fifo1_rdreq(fifo1_rdreq),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_done(tx_done),
      .busy(busy), .cur_ch(cur_ch), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   // Normal-mode FIFOs: data one cycle after rdreq, empty reflects the pop.
   always @(posedge clk) begin
      if (fifo0_rdreq && fifo1_rdreq) rd_both++;
      if (fifo0_rdreq) begin
         rd0_cnt++;
         if (q0.size() == 0) underflow++; else fifo0_q <= q0.pop_front();
      end
      if (fifo1_rdreq) begin
         rd1_cnt++;
         if (q1.size() == 0) underflow++; else fifo1_q <= q1.pop_front();
      end
      fifo0_empty <= (q0.size() == 0);
      fifo1_empty <= (q1.size() == 0);
   end

   // Transmitter: accepts a byte after a delay and watches byte stability.
   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_done = 1'b0; tx_cnt = 0; prev_valid = 1'b0;
      end else begin
         if (prev_valid && !tx_done && (!tx_valid || tx_data !== prev_data)) stab_err++;
         prev_valid = tx_valid; prev_data = tx_data;
         if (tx_done) tx_done = 1'b0;
         else if (tx_mode == 2) tx_done = ($urandom_range(0, 3) == 0);
         else if (tx_mode == 1 && tx_valid) begin
            tx_cnt++;
            if (tx_cnt >= ((got.size() == hold_idx) ? hold_delay : tx_delay)) begin
               tx_done = 1'b1; got.push_back(tx_data); tx_cnt = 0;
            end
         end
      end
   end

   task automatic push_word(input int ch, input logic [13:0] w);
      if (ch == 0) begin q0.push_back(w); m0.push_back(w); end
      else         begin q1.push_back(w); m1.push_back(w); end
   endtask

   task automatic load_rand(input int ch, input int n);
      for (int i = 0; i < n; i++) push_word(ch, 14'($urandom_range(0, 16383)));
   endtask

   // Reference: drain model queues frame by frame using the framing rules.
   task automatic run_model();
      logic ch;
      int n;
      logic [13:0] w;
      while (m0.size() != 0 || m1.size() != 0) begin
         if (m0.size() != 0 && m1.size() != 0) ch = ~m_last;
         else ch = (m1.size() != 0);
         n = ch ? m1.size() : m0.size();
         if (n > BURST) n = BURST;
         exp_bytes.push_back(8'hA5);
         exp_bytes.push_back({7'b0, ch});
         for (int i = 0; i < n; i++) begin
            w = ch ? m1.pop_front() : m0.pop_front();
            exp_bytes.push_back({2'b00, w[13:8]});
            exp_bytes.push_back(w[7:0]);
         end
         exp_bytes.push_back(8'hC0 | 8'(n));
         m_last = ch;
         exp_frames = exp_frames + 16'd1;
      end
   endtask

   function automatic int first_diff();
      int n = (got.size() < exp_bytes.size()) ? got.size() : exp_bytes.size();
      for (int i = 0; i < n; i++) if (got[i] !== exp_bytes[i]) return i;
      if (got.size() != exp_bytes.size()) return n;
      return -1;
   endfunction

   task automatic wait_done(input int budget, output bit timed_out);
      int c = 0;
      repeat (3) @(negedge clk);
      while (!(got.size() >= exp_bytes.size() && !busy && q0.size() == 0 && q1.size() == 0)
             && c < budget) begin
         @(negedge clk); c++;
      end
      timed_out = (c >= budget);
      repeat (3) @(negedge clk);
   endtask

   task automatic start_stream();
      got.delete(); exp_bytes.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      compared++;
      if ({tx_valid, busy, cur_ch, fifo0_rdreq, fifo1_rdreq, frame_cnt, tx_data} !==
          {1'b0, 1'b0, 1'b1, 2'b00, 16'h0000, 8'h00}) begin
         mismatched++;
         $display("FAIL reset_values: valid=%b busy=%b ch=%b rd=%b%b fc=%h data=%h, required 0 0 1 00 0000 00",
                  tx_valid, busy, cur_ch, fifo1_rdreq, fifo0_rdreq, frame_cnt, tx_data);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic();
      logic [7:0] ref_b [9] = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h00, 8'h01, 8'h3F, 8'hFF, 8'hC3};
      int rd0 = rd0_cnt;
      bit to;
      tx_delay = 4;
      start_stream();
      push_word(0, 14'h1234); push_word(0, 14'h0001); push_word(0, 14'h3FFF);
      run_model();
      wait_done(5000, to);
      compared++;
      if (to) begin mismatched++; $display("FAIL basic_timeout: got %0d bytes, required 9", got.size()); end
      compared++;
      if (got.size() != 9) begin
         mismatched++; $display("FAIL basic_len: got %0d bytes, required 9", got.size());
      end else begin
         for (int i = 0; i < 9; i++) begin
            compared++;
            if (got[i] !== ref_b[i]) begin
               mismatched++; $display("FAIL basic_byte%0d: got %h, required %h", i, got[i], ref_b[i]);
            end
         end
      end
      compared++;
      if (frame_cnt !== 16'd1) begin mismatched++; $display("FAIL basic_frame_cnt: got %0d, required 1", frame_cnt); end
      compared++;
      if (rd0_cnt - rd0 != 3) begin mismatched++; $display("FAIL basic_rdreq0: got %0d pulses, required 3", rd0_cnt - rd0); end
   endtask

   task automatic test_stream(input string name, input int n0, input int n1, input int dly);
      int rd0 = rd0_cnt, rd1 = rd1_cnt, d;
      bit to;
      tx_delay = dly;
      start_stream();
      load_rand(0, n0); load_rand(1, n1);
      run_model();
      wait_done(30000, to);
      compared++;
      if (to) begin mismatched++; $display("FAIL %s_timeout: got %0d bytes, required %0d", name, got.size(), exp_bytes.size()); end
      d = first_diff();
      compared++;
      if (d != -1) begin
         mismatched++;
         $display("FAIL %s_stream: at byte %0d got %h (len %0d), required %h (len %0d)", name, d,
                  (d < got.size()) ? got[d] : 8'hxx, got.size(), (d < exp_bytes.size()) ? exp_bytes[d] : 8'hxx, exp_bytes.size());
      end
      compared++;
      if (frame_cnt !== exp_frames) begin mismatched++; $display("FAIL %s_frame_cnt: got %0d, required %0d", name, frame_cnt, exp_frames); end
      compared++;
      if (cur_ch !== m_last) begin mismatched++; $display("FAIL %s_cur_ch: got %b, required %b", name, cur_ch, m_last); end
      compared++;
      if (rd0_cnt - rd0 != n0 || rd1_cnt - rd1 != n1) begin
         mismatched++; $display("FAIL %s_rd_counts: got %0d/%0d, required %0d/%0d", name, rd0_cnt - rd0, rd1_cnt - rd1, n0, n1);
      end
   endtask

   task automatic test_back_to_back();
      test_stream("both20", 20, 20, 2);
   endtask

   task automatic test_idle_empty();
      int act = 0;
      logic [15:0] fc = exp_frames;
      tx_mode = 2;
      repeat (200) begin
         @(negedge clk);
         if (tx_valid || busy || fifo0_rdreq || fifo1_rdreq) act++;
      end
      tx_mode = 1;
      repeat (2) @(negedge clk);
      compared++;
      if (act != 0) begin mismatched++; $display("FAIL idle_activity: got %0d active cycles, required 0", act); end
      compared++;
      if (frame_cnt !== fc) begin mismatched++; $display("FAIL idle_frame_cnt: got %0d, required %0d", frame_cnt, fc); end
   endtask

   task automatic test_hold();
      logic [13:0] w0 = 14'($urandom_range(0, 16383));
      logic [7:0] snap;
      int bad = 0, c = 0, rd0 = rd0_cnt, st = stab_err, d;
      bit to;
      tx_delay = 3;
      start_stream();
      push_word(0, w0); load_rand(0, 1);
      run_model();
      hold_idx = 2; hold_delay = 100;
      while (got.size() < 2 && c < 1000) begin @(negedge clk); c++; end
      repeat (2) @(negedge clk);
      snap = tx_data;
      compared++;
      if (!tx_valid || snap !== {2'b00, w0[13:8]}) begin
         mismatched++; $display("FAIL hold_hi_byte: got valid=%b data=%h, required valid=1 data=%h", tx_valid, snap, {2'b00, w0[13:8]});
      end
      repeat (90) begin
         @(negedge clk);
         if (!tx_valid || tx_data !== snap || fifo0_rdreq || fifo1_rdreq) bad++;
      end
      compared++;
      if (bad != 0 || rd0_cnt - rd0 != 1) begin
         mismatched++; $display("FAIL hold_stable: got %0d unstable cycles, %0d reads, required 0 and 1", bad, rd0_cnt - rd0);
      end
      hold_idx = -1;
      wait_done(5000, to);
      d = first_diff();
      compared++;
      if (to || d != -1) begin mismatched++; $display("FAIL hold_stream: timeout=%0b first diff at %0d, required none", to, d); end
      compared++;
      if (stab_err != st) begin mismatched++; $display("FAIL hold_handshake: got %0d violations, required 0", stab_err - st); end
   endtask

   task automatic test_random();
      for (int it = 0; it < 4; it++)
         test_stream($sformatf("rand%0d", it), $urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(1, 5));
   endtask

   task automatic test_reset_mid();
      logic [13:0] w1;
      int c = 0, d;
      bit to;
      tx_delay = 2;
      start_stream();
      load_rand(0, 3);
      w1 = m0[1];
      run_model();
      hold_idx = 5; hold_delay = 100000;
      while (got.size() < 5 && c < 1000) begin @(negedge clk); c++; end
      repeat (3) @(negedge clk);
      compared++;
      if (!tx_valid || tx_data !== w1[7:0]) begin
         mismatched++; $display("FAIL midrst_lo_byte: got valid=%b data=%h, required 1 %h", tx_valid, tx_data, w1[7:0]);
      end
      #1 rst_n = 1'b0;
      #1;
      compared++;
      if ({tx_valid, busy, cur_ch, fifo0_rdreq, fifo1_rdreq, frame_cnt, tx_data} !==
          {1'b0, 1'b0, 1'b1, 2'b00, 16'h0000, 8'h00}) begin
         mismatched++;
         $display("FAIL midrst_values: valid=%b busy=%b ch=%b rd=%b%b fc=%h data=%h, required 0 0 1 00 0000 00",
                  tx_valid, busy, cur_ch, fifo1_rdreq, fifo0_rdreq, frame_cnt, tx_data);
      end
      hold_idx = -1;
      start_stream();
      m0 = q0; m1.delete(); m_last = 1'b1; exp_frames = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_model();
      wait_done(5000, to);
      compared++;
      if (got.size() < 2 || got[0] !== 8'hA5 || got[1] !== 8'h00) begin
         mismatched++; $display("FAIL midrst_header: got %0d bytes starting %h %h, required A5 00", got.size(),
                                (got.size() > 0) ? got[0] : 8'hxx, (got.size() > 1) ? got[1] : 8'hxx);
      end
      d = first_diff();
      compared++;
      if (to || d != -1) begin mismatched++; $display("FAIL midrst_stream: timeout=%0b first diff at %0d, required none", to, d); end
      compared++;
      if (frame_cnt !== exp_frames) begin mismatched++; $display("FAIL midrst_frame_cnt: got %0d, required %0d", frame_cnt, exp_frames); end
   endtask

   task automatic test_wrap();
      bit to;
      @(negedge clk);
      force dut.r_frame_cnt = 16'hFFFF;
      @(negedge clk);
      release dut.r_frame_cnt;
      exp_frames = 16'hFFFF;
      start_stream();
      load_rand($urandom_range(0, 1), 1);
      run_model();
      wait_done(5000, to);
      compared++;
      if (to || frame_cnt !== 16'h0000) begin
         mismatched++; $display("FAIL wrap_frame_cnt: timeout=%0b got %h, required 0000", to, frame_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_idle_empty();
      test_hold();
      test_random();
      test_reset_mid();
      test_wrap();
      compared++;
      if (underflow != 0 || rd_both != 0 || stab_err != 0) begin
         mismatched++; $display("FAIL global_invariants: underflow=%0d both_rdreq=%0d handshake=%0d, required 0 0 0",
                                underflow, rd_both, stab_err);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
